// File: rtl/cu_fsm.sv
// Multicycle RV32I control sequencer: steps instructions through FETCH/EXEC/WB,
// issues PC/regfile/memory/CSR strobes and handles machine-mode interrupt entry.
module cu_fsm #(
    parameter int INIT_CYCLES  = 2,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] cu_opcode,
    input  logic [2:0] func3,
    input  logic       intr,
    input  logic       csr_mie,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       reg_write,
    output logic       mem_rden1,
    output logic       mem_rden2,
    output logic       mem_we2,
    output logic       csr_we,
    output logic       mret_exec,
    output logic       int_taken,
    output logic       illegal,
    output logic       fault,
    output logic [2:0] dbg_state
);

    localparam int CNT_MAX = (INIT_CYCLES > MEM_WAIT_MAX) ? INIT_CYCLES : MEM_WAIT_MAX;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] INIT_LAST = CW'(INIT_CYCLES - 1);
    // The cycle that would make the wait count reach MEM_WAIT_MAX is the last one tolerated.
    localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_WAIT_MAX - 1);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WB    = 3'd3,
        ST_INTR  = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

    state_t        state, state_nxt, end_state;
    logic [CW-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        pc_write  = 1'b0;
        reg_write = 1'b0;
        mem_rden1 = 1'b0;
        mem_rden2 = 1'b0;
        mem_we2   = 1'b0;
        csr_we    = 1'b0;
        mret_exec = 1'b0;
        int_taken = 1'b0;
        illegal   = 1'b0;
        fault     = 1'b0;
        state_nxt = state;
        // Interrupts are only honoured where an instruction retires.
        end_state = (intr && csr_mie) ? ST_INTR : ST_FETCH;

        case (state)
            ST_INIT: begin
                if (cnt == INIT_LAST) state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                mem_rden1 = 1'b1;
                if (mem_ready)              state_nxt = ST_EXEC;
                else if (cnt == WAIT_LAST)  state_nxt = ST_ERR;
            end
            ST_EXEC: begin
                state_nxt = end_state;
                case (cu_opcode)
                    OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OP_IMM, OPC_OP: begin
                        pc_write  = 1'b1;
                        reg_write = 1'b1;
                    end
                    OPC_BRANCH: pc_write = 1'b1;
                    OPC_STORE: begin
                        mem_we2  = 1'b1;
                        pc_write = 1'b1;
                    end
                    OPC_LOAD: begin
                        mem_rden2 = 1'b1;
                        state_nxt = ST_WB;
                    end
                    OPC_SYSTEM: begin
                        pc_write = 1'b1;
                        if (func3 != 3'd0) begin
                            csr_we    = 1'b1;
                            reg_write = 1'b1;
                        end else begin
                            mret_exec = 1'b1;
                        end
                    end
                    default: begin
                        illegal  = 1'b1;
                        pc_write = 1'b1;
                    end
                endcase
            end
            ST_WB: begin
                if (mem_ready) begin
                    reg_write = 1'b1;
                    pc_write  = 1'b1;
                    state_nxt = end_state;
                end else begin
                    mem_rden2 = 1'b1;
                    if (cnt == WAIT_LAST) state_nxt = ST_ERR;
                end
            end
            ST_INTR: begin
                int_taken = 1'b1;
                pc_write  = 1'b1;
                state_nxt = ST_FETCH;
            end
            ST_ERR: begin
                fault = 1'b1;
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    always_comb begin
        cnt_nxt = cnt;
        if (state_nxt != state)
            cnt_nxt = '0;
        else if (state == ST_INIT || state == ST_FETCH || state == ST_WB)
            cnt_nxt = cnt + 1'b1;
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_cu_fsm.sv
// Bench for cu_fsm: builds a per-cycle stimulus trace and the expected strobe
// vector for each cycle from instruction-level rules, then replays and compares.
module tb_cu_fsm;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Expected vector: {pc_write,reg_write,rden1,rden2,we2,csr_we,mret,int_taken,illegal,fault}
    localparam logic [9:0] E_PCW   = 10'b1000000000;
    localparam logic [9:0] E_REGW  = 10'b0100000000;
    localparam logic [9:0] E_RD1   = 10'b0010000000;
    localparam logic [9:0] E_RD2   = 10'b0001000000;
    localparam logic [9:0] E_WE2   = 10'b0000100000;
    localparam logic [9:0] E_CSR   = 10'b0000010000;
    localparam logic [9:0] E_MRET  = 10'b0000001000;
    localparam logic [9:0] E_INT   = 10'b0000000100;
    localparam logic [9:0] E_ILL   = 10'b0000000010;
    localparam logic [9:0] E_FAULT = 10'b0000000001;
    localparam int         WAIT_MAX = 15;

    typedef struct packed {
        logic [6:0] op;
        logic [2:0] f3;
        logic       irq;
        logic       mie;
        logic       rdy;
    } stim_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] cu_opcode = '0;
    logic [2:0] func3 = '0;
    logic       intr = 1'b0;
    logic       csr_mie = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, reg_write, mem_rden1, mem_rden2, mem_we2;
    logic       csr_we, mret_exec, int_taken, illegal, fault;
    logic [2:0] dbg_state;

    stim_t      stim_q[$];
    logic [9:0] exp_q[$];
    int         checks = 0;
    int         failures = 0;
    int         cycle = 0;

    cu_fsm dut (
        .clk(clk), .rst_n(rst_n), .cu_opcode(cu_opcode), .func3(func3),
        .intr(intr), .csr_mie(csr_mie), .mem_ready(mem_ready),
        .pc_write(pc_write), .reg_write(reg_write), .mem_rden1(mem_rden1),
        .mem_rden2(mem_rden2), .mem_we2(mem_we2), .csr_we(csr_we),
        .mret_exec(mret_exec), .int_taken(int_taken), .illegal(illegal),
        .fault(fault), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] observed();
        return {pc_write, reg_write, mem_rden1, mem_rden2, mem_we2,
                csr_we, mret_exec, int_taken, illegal, fault};
    endfunction

    function automatic stim_t rnd_stim(input logic rdy);
        stim_t s;
        s.op  = 7'($urandom);
        s.f3  = 3'($urandom);
        s.irq = 1'($urandom);
        s.mie = 1'($urandom);
        s.rdy = rdy;
        return s;
    endfunction

    // Strobes an instruction should raise in its execute cycle.
    function automatic logic [9:0] exec_exp(input logic [6:0] op, input logic [2:0] f3);
        case (op)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OP_IMM, OPC_OP: return E_PCW | E_REGW;
            OPC_BRANCH: return E_PCW;
            OPC_STORE:  return E_PCW | E_WE2;
            OPC_LOAD:   return E_RD2;
            OPC_SYSTEM: return (f3 != 3'd0) ? (E_PCW | E_REGW | E_CSR) : (E_PCW | E_MRET);
            default:    return E_PCW | E_ILL;
        endcase
    endfunction

    task automatic push(input stim_t s, input logic [9:0] e);
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    task automatic push_init();
        repeat (2) push(rnd_stim(1'($urandom)), 10'b0);
    endtask

    task automatic push_fetch(input int fd);
        repeat (fd) push(rnd_stim(1'b0), E_RD1);
        push(rnd_stim(1'b1), E_RD1);
    endtask

    // One full instruction: fetch wait fd, load wait wd, interrupt lines at retirement.
    task automatic push_instr(input logic [6:0] op, input logic [2:0] f3, input int fd,
                              input int wd, input logic irq_end, input logic mie_end);
        stim_t s;
        push_fetch(fd);
        s = rnd_stim(1'($urandom));
        s.op = op;
        s.f3 = f3;
        if (op != OPC_LOAD) begin
            s.irq = irq_end;
            s.mie = mie_end;
        end
        push(s, exec_exp(op, f3));
        if (op == OPC_LOAD) begin
            repeat (wd) push(rnd_stim(1'b0), E_RD2);
            s = rnd_stim(1'b1);
            s.irq = irq_end;
            s.mie = mie_end;
            push(s, E_PCW | E_REGW);
        end
        if (irq_end && mie_end) push(rnd_stim(1'($urandom)), E_PCW | E_INT);
    endtask

    task automatic push_random_instrs(input int n);
        logic [6:0] ops[12];
        ops = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OP_IMM, OPC_OP,
                OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_SYSTEM, 7'b0000000, 7'b1111111};
        for (int i = 0; i < n; i++)
            push_instr(ops[$urandom_range(0, 11)], 3'($urandom), $urandom_range(0, 4),
                       $urandom_range(0, 4), 1'($urandom), 1'($urandom));
    endtask

    task automatic push_err(input int n);
        repeat (n) push(rnd_stim(1'($urandom)), E_FAULT);
    endtask

    task automatic check(input string tag, input logic [9:0] exp);
        logic [9:0] obs;
        obs = observed();
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cycle, obs, exp);
        end
    endtask

    task automatic drive(input stim_t s);
        cu_opcode = s.op;
        func3     = s.f3;
        intr      = s.irq;
        csr_mie   = s.mie;
        mem_ready = s.rdy;
    endtask

    // Called right after a negedge; leaves the bench just after a negedge.
    task automatic replay(input string tag);
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            #1;
            check(tag, exp_q.pop_front());
            cycle++;
            @(negedge clk);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("reset_async", 10'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        stim_t s;

        // Scenario 1: directed instructions, random mix, then fetch timeout.
        apply_reset();
        push_init();
        push_instr(OPC_OP, 3'd0, 0, 0, 1'b0, 1'b0);
        push_instr(OPC_STORE, 3'd2, 1, 0, 1'b0, 1'b0);
        push_instr(OPC_LOAD, 3'd2, 0, 3, 1'b0, 1'b0);
        push_instr(OPC_OP, 3'd0, 3, 0, 1'b1, 1'b1);
        push_instr(OPC_OP_IMM, 3'd0, 0, 0, 1'b1, 1'b0);
        push_instr(7'b0000000, 3'd0, 0, 0, 1'b0, 1'b0);
        push_instr(OPC_SYSTEM, 3'd0, 0, 0, 1'b1, 1'b1);
        push_instr(OPC_SYSTEM, 3'd2, 0, 0, 1'b0, 1'b1);
        push_instr(OPC_LOAD, 3'd0, 2, 2, 1'b1, 1'b1);
        push_random_instrs(25);
        repeat (WAIT_MAX) push(rnd_stim(1'b0), E_RD1);
        push_err(6);
        replay("s1");

        // Scenario 2: random mix, then a load that never completes.
        apply_reset();
        push_init();
        push_random_instrs(12);
        push_instr(OPC_BRANCH, 3'd1, 0, 0, 1'b0, 1'b1);
        push_fetch(1);
        s = rnd_stim(1'b1);
        s.op = OPC_LOAD;
        push(s, E_RD2);
        repeat (WAIT_MAX) push(rnd_stim(1'b0), E_RD2);
        push_err(5);
        replay("s2");

        // Scenario 3: reset asserted while a load waits in WB.
        apply_reset();
        push_init();
        push_fetch(0);
        s = rnd_stim(1'b1);
        s.op = OPC_LOAD;
        push(s, E_RD2);
        repeat (2) push(rnd_stim(1'b0), E_RD2);
        replay("s3");
        drive(rnd_stim(1'b0));
        #1;
        check("s3_wb_hold", E_RD2);
        #2;
        rst_n = 1'b0;
        #1;
        check("s3_reset_mid_wb", 10'b0);
        @(negedge clk);
        rst_n = 1'b1;
        push_init();
        push_random_instrs(6);
        replay("s3_recover");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
